// File: rtl/gray_monitor.sv
// Gray-code stream monitor: converts each qualified Gray sample to binary, checks for
// single forward steps, counts laps and illegal transitions, and halts after ERR_MAX errors.
module gray_monitor #(
  parameter int WIDTH = 3,
  parameter int LAP_W = 8,
  parameter int ERR_W = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Clear,
  input  logic             Valid,
  input  logic [WIDTH-1:0] Gray_In,
  output logic [WIDTH-1:0] Binary,
  output logic             Step,
  output logic             Wrap,
  output logic [LAP_W-1:0] Laps,
  output logic             Error,
  output logic [ERR_W-1:0] Err_Count,
  output logic             Halted
);

  localparam logic [ERR_W-1:0] ERR_MAX  = '1;
  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  typedef enum logic [1:0] {SYNC, TRACK, HALT} state_t;

  state_t             state, state_nxt;
  logic [WIDTH-1:0]   bin_nxt;
  logic               step_nxt, wrap_nxt, err_nxt;
  logic [LAP_W-1:0]   laps_nxt;
  logic [ERR_W-1:0]   cnt_nxt, cnt_inc;
  logic [WIDTH-1:0]   samp_bin;

  function automatic logic [WIDTH-1:0] gray2bin(input logic [WIDTH-1:0] g);
    logic [WIDTH-1:0] b;
    b[WIDTH-1] = g[WIDTH-1];
    for (int i = WIDTH - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] c);
    return (c == ERR_MAX) ? c : c + ERR_W'(1);
  endfunction

  assign samp_bin = gray2bin(Gray_In);
  assign cnt_inc  = sat_inc(Err_Count);
  assign Halted   = (state == HALT);

  // Binary doubles as the tracking reference: both always hold the last accepted value.
  always_comb begin
    state_nxt = state;
    bin_nxt   = Binary;
    step_nxt  = 1'b0;
    wrap_nxt  = 1'b0;
    laps_nxt  = Laps;
    err_nxt   = Error;
    cnt_nxt   = Err_Count;
    if (Clear) begin
      state_nxt = SYNC;
      bin_nxt   = '0;
      laps_nxt  = '0;
      err_nxt   = 1'b0;
      cnt_nxt   = '0;
    end else if (Valid) begin
      case (state)
        SYNC: begin
          bin_nxt   = samp_bin;
          state_nxt = TRACK;
        end
        TRACK: begin
          if (samp_bin == Binary) begin
            bin_nxt = Binary;
          end else if (Binary != ALL_ONES && samp_bin == Binary + WIDTH'(1)) begin
            step_nxt = 1'b1;
            bin_nxt  = samp_bin;
          end else if (Binary == ALL_ONES && samp_bin == '0) begin
            step_nxt = 1'b1;
            wrap_nxt = 1'b1;
            laps_nxt = Laps + LAP_W'(1);
            bin_nxt  = '0;
          end else begin
            err_nxt = 1'b1;
            cnt_nxt = cnt_inc;
            bin_nxt = samp_bin;
            if (cnt_inc == ERR_MAX) state_nxt = HALT;
          end
        end
        HALT:    state_nxt = HALT;
        default: state_nxt = SYNC;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= SYNC;
      Binary    <= '0;
      Step      <= 1'b0;
      Wrap      <= 1'b0;
      Laps      <= '0;
      Error     <= 1'b0;
      Err_Count <= '0;
    end else begin
      state     <= state_nxt;
      Binary    <= bin_nxt;
      Step      <= step_nxt;
      Wrap      <= wrap_nxt;
      Laps      <= laps_nxt;
      Error     <= err_nxt;
      Err_Count <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_gray_monitor.sv
// Scoreboard bench for gray_monitor: directed test-plan sequences, a long legal run that
// wraps Laps, and randomized traffic against a behavioural model of the monitor rules.
module tb_gray_monitor;

  logic       Clk = 1'b0;
  logic       Reset, Clear, Valid;
  logic [2:0] Gray_In;
  logic [2:0] Binary;
  logic       Step, Wrap, Error, Halted;
  logic [7:0] Laps;
  logic [1:0] Err_Count;

  gray_monitor #(.WIDTH(3), .LAP_W(8), .ERR_W(2)) dut (
    .Clk(Clk), .Reset(Reset), .Clear(Clear), .Valid(Valid), .Gray_In(Gray_In),
    .Binary(Binary), .Step(Step), .Wrap(Wrap), .Laps(Laps), .Error(Error),
    .Err_Count(Err_Count), .Halted(Halted)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [2:0] bin;
    logic       step;
    logic       wrap;
    logic [7:0] laps;
    logic       err;
    logic [1:0] cnt;
    logic       halted;
  } out_t;

  out_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  bit   done  = 0;

  // behavioural model state
  int m_bin, m_laps, m_cnt;
  bit m_err, m_synced, m_halted, m_step, m_wrap;

  function automatic int gray_of(int b);
    return (b ^ (b >> 1)) & 7;
  endfunction

  function automatic int g2b(int g);
    for (int b = 0; b < 8; b++) if (gray_of(b) == g) return b;
    return 0;
  endfunction

  task automatic model_zero();
    m_bin = 0; m_laps = 0; m_cnt = 0;
    m_err = 0; m_synced = 0; m_halted = 0; m_step = 0; m_wrap = 0;
  endtask

  task automatic model_step(bit rst_n, bit clr, bit vld, int g);
    int n;
    m_step = 0;
    m_wrap = 0;
    if (!rst_n || clr) begin
      model_zero();
    end else if (vld && !m_halted) begin
      n = g2b(g);
      if (!m_synced) begin
        m_bin = n;
        m_synced = 1;
      end else if (n == m_bin) begin
        m_bin = n;
      end else if (n == (m_bin + 1) % 8) begin
        m_step = 1;
        if (m_bin == 7) begin
          m_wrap = 1;
          m_laps = (m_laps + 1) % 256;
        end
        m_bin = n;
      end else begin
        m_err = 1;
        if (m_cnt < 3) m_cnt++;
        m_bin = n;
        if (m_cnt == 3) m_halted = 1;
      end
    end
  endtask

  function automatic out_t model_out();
    out_t e;
    e.bin = 3'(m_bin); e.step = m_step; e.wrap = m_wrap; e.laps = 8'(m_laps);
    e.err = m_err; e.cnt = 2'(m_cnt); e.halted = m_halted;
    return e;
  endfunction

  task automatic cyc(bit rst_n, bit clr, bit vld, int g);
    @(negedge Clk);
    Reset = rst_n; Clear = clr; Valid = vld; Gray_In = 3'(g);
    model_step(rst_n, clr, vld, g);
    exp_q.push_back(model_out());
  endtask

  task automatic check_zero(string name);
    out_t got;
    got = {Binary, Step, Wrap, Laps, Error, Err_Count, Halted};
    total++;
    if (got !== '0) begin
      bad++;
      $display("FAIL %s: got bin=%0d step=%b wrap=%b laps=%0d err=%b cnt=%0d halted=%b, need all 0",
               name, Binary, Step, Wrap, Laps, Error, Err_Count, Halted);
    end
  endtask

  // monitor: every clock edge produces an output word; compare against the oldest expectation
  initial begin
    out_t got, e;
    int   n = 0;
    forever begin
      @(posedge Clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {Binary, Step, Wrap, Laps, Error, Err_Count, Halted};
        total++;
        n++;
        if (got !== e) begin
          bad++;
          $display("FAIL sample%0d: got bin=%0d step=%b wrap=%b laps=%0d err=%b cnt=%0d halted=%b, need bin=%0d step=%b wrap=%b laps=%0d err=%b cnt=%0d halted=%b",
                   n, got.bin, got.step, got.wrap, got.laps, got.err, got.cnt, got.halted,
                   e.bin, e.step, e.wrap, e.laps, e.err, e.cnt, e.halted);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int g, r, lap_seq[9], hlt_seq[4];
    lap_seq = '{0, 1, 3, 2, 6, 7, 5, 4, 0};
    hlt_seq = '{3, 1, 7, 1};
    Reset = 1'b1; Clear = 1'b0; Valid = 1'b0; Gray_In = 3'd0;
    model_zero();
    #1 Reset = 1'b0;
    #1 check_zero("reset_async");
    cyc(0, 0, 1, 3);
    cyc(0, 0, 0, 0);

    // full lap from reset
    foreach (lap_seq[i]) cyc(1, 0, 1, lap_seq[i]);

    // hold and gaps
    cyc(1, 1, 0, 0);
    repeat (3) cyc(1, 0, 1, 3);
    for (int i = 0; i < 4; i++) cyc(1, 0, 0, (i % 2) ? 5 : 6);

    // illegal jump then legal step
    cyc(1, 1, 0, 0);
    cyc(1, 0, 1, 1);
    cyc(1, 0, 1, 2);
    cyc(1, 0, 1, 6);

    // three errors to HALT, then an ignored legal sample
    cyc(1, 1, 0, 0);
    foreach (hlt_seq[i]) cyc(1, 0, 1, hlt_seq[i]);
    cyc(1, 0, 1, 3);
    cyc(1, 0, 0, 2);

    // Clear with Valid while halted drops the sample; next sample only resyncs
    cyc(1, 1, 1, 3);
    cyc(1, 0, 1, 1);
    cyc(1, 0, 1, 3);

    // reset mid-lap, between edges
    cyc(1, 0, 1, 2);
    @(negedge Clk);
    #2 Reset = 1'b0;
    #1 check_zero("reset_midlap");
    model_step(0, 0, 0, 0);
    cyc(0, 0, 1, 6);
    cyc(1, 0, 1, 7);
    cyc(1, 0, 1, 5);

    // 257 legal laps so Laps wraps modulo 256
    cyc(1, 1, 0, 0);
    for (int i = 0; i <= 257 * 8; i++) cyc(1, 0, 1, gray_of(i % 8));

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      r = $urandom_range(0, 99);
      if (r < 60)      g = gray_of((m_bin + 1) % 8);
      else if (r < 75) g = gray_of(m_bin);
      else             g = $urandom_range(0, 7);
      cyc(1, ($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), g);
    end
    cyc(1, 0, 0, 0);

    repeat (3) @(posedge Clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expectations, need 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
